// File: rtl/inst_axi_bridge_if.sv
// Bus bundles for inst_axi_bridge: fetch-side request/response and AXI4 read channels.
// inst_buserr exists only when INST_BUS_ERR_EN is defined.
interface inst_fetch_if;
  logic        inst_req;
  logic        inst_cache;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_cancel;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
`ifdef INST_BUS_ERR_EN
  logic        inst_buserr;

  modport master (
    output inst_req, inst_cache, inst_addr, inst_cancel,
    input  inst_addr_ok, inst_data_ok, inst_rdata, inst_buserr
  );
  modport slave (
    input  inst_req, inst_cache, inst_addr, inst_cancel,
    output inst_addr_ok, inst_data_ok, inst_rdata, inst_buserr
  );
`else
  modport master (
    output inst_req, inst_cache, inst_addr, inst_cancel,
    input  inst_addr_ok, inst_data_ok, inst_rdata
  );
  modport slave (
    input  inst_req, inst_cache, inst_addr, inst_cancel,
    output inst_addr_ok, inst_data_ok, inst_rdata
  );
`endif
endinterface

interface axi_rd_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arcache;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arcache, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );
  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arcache, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/inst_axi_bridge.sv
// Fetch-request to AXI4 single-beat read bridge with in-order return and flush discard.
// Optional INST_BUS_ERR_EN adds inst_buserr, reporting rresp[1] of delivered beats.
module inst_axi_bridge #(
  parameter int          MAX_OUT  = 4,
  parameter logic [3:0]  ARID_VAL = 4'd0
) (
  input  logic          clk,
  input  logic          reset,
  inst_fetch_if.slave   inst,
  axi_rd_if.master      axi
);

  localparam logic [3:0] MAX_OUT_C = 4'(MAX_OUT);

  logic [3:0] out_cnt;
  logic [3:0] drop_cnt;
  logic       accept;
  logic       ar_hs;
  logic       r_hs;
  logic       deliver;
  logic       unused_bits;

  assign ar_hs   = axi.arvalid && axi.arready;
  assign r_hs    = axi.rvalid && axi.rlast;
  assign deliver = r_hs && (drop_cnt == 4'd0);
  assign accept  = inst.inst_req && !inst.inst_cancel &&
                   (out_cnt < MAX_OUT_C) && (!axi.arvalid || axi.arready);

  assign inst.inst_addr_ok = accept;

  assign axi.arid    = ARID_VAL;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = 3'd2;
  assign axi.arburst = 2'b01;
  assign axi.rready  = 1'b1;

  assign unused_bits = ^{axi.rid, axi.rresp};

  // A new accept may reload the AR slot in the same cycle the old request handshakes.
  always_ff @(posedge clk) begin
    if (reset) begin
      axi.arvalid <= 1'b0;
      axi.araddr  <= 32'd0;
      axi.arcache <= 4'd0;
    end else if (accept) begin
      axi.arvalid <= 1'b1;
      axi.araddr  <= inst.inst_addr;
      axi.arcache <= inst.inst_cache ? 4'b1111 : 4'b0000;
    end else if (ar_hs) begin
      axi.arvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_cnt <= 4'd0;
    end else if (accept && !r_hs) begin
      out_cnt <= out_cnt + 4'd1;
    end else if (!accept && r_hs && out_cnt != 4'd0) begin
      out_cnt <= out_cnt - 4'd1;
    end
  end

  // On a flush everything still outstanding after this cycle's return becomes a drop,
  // which already includes any older drops, so the count is rebuilt rather than added.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= 4'd0;
    end else if (inst.inst_cancel) begin
      drop_cnt <= (r_hs && out_cnt != 4'd0) ? out_cnt - 4'd1 : out_cnt;
    end else if (r_hs && drop_cnt != 4'd0) begin
      drop_cnt <= drop_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inst.inst_data_ok <= 1'b0;
      inst.inst_rdata   <= 32'd0;
    end else begin
      inst.inst_data_ok <= deliver;
      if (deliver) begin
        inst.inst_rdata <= axi.rdata;
      end
    end
  end

`ifdef INST_BUS_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      inst.inst_buserr <= 1'b0;
    end else begin
      inst.inst_buserr <= deliver && axi.rresp[1];
    end
  end
`endif

endmodule
